// File: rtl/muldiv_unit.sv
// Purpose: HI/LO multiply/divide unit (MULT(U), DIV(U), MADD(U), MSUB(U), MTHI, MTLO).
// Latency: MTHI/MTLO write at the issue edge; multiply class commits MUL_LAT edges after issue, divide class DIV_LAT.
// Backpressure: busy=1 while an op is in flight; start is dropped (not queued) while busy or flush is high.
//
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   start, op, a, b - issue strobe, op code (0..10, others NOP), operands (a = dividend / MTHI/MTLO source)
//   flush           - aborts the in-flight op; hi/lo untouched, no done
//   hi, lo          - architectural HI/LO registers
//   busy, done      - op in flight; one-cycle pulse after a multi-cycle commit
module muldiv_unit #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);
    localparam int W2 = 2 * WIDTH;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    localparam logic [7:0] MUL_CNT = 8'(MUL_LAT);
    localparam logic [7:0] DIV_CNT = 8'(DIV_LAT);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d;

    // ---------------- datapath on latched operands ----------------
    logic signed [W2-1:0] sa_ext, sb_ext;
    logic [W2-1:0]        prod_s, prod_u, result;

    assign sa_ext = {{WIDTH{a_q[WIDTH-1]}}, a_q};
    assign sb_ext = {{WIDTH{b_q[WIDTH-1]}}, b_q};
    // Truncating the 2W-bit products keeps them exact modulo 2^(2W).
    assign prod_s = sa_ext * sb_ext;
    assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

    // Signed divide via magnitudes. The -2^(W-1)/-1 case falls out naturally:
    // |a| = 2^(W-1) as unsigned, quotient 2^(W-1) wraps back to a, remainder 0.
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] abs_a, abs_b, div_b, uq, ur, quo, rem;
    logic [W2-1:0]    div_res;

    assign a_neg   = (op_q == OP_DIV) && a_q[WIDTH-1];
    assign b_neg   = (op_q == OP_DIV) && b_q[WIDTH-1];
    assign abs_a   = a_neg ? -a_q : a_q;
    assign abs_b   = b_neg ? -b_q : b_q;
    // Divisor forced non-zero so the divider never sees /0; that result is overridden below.
    assign div_b   = (b_q == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : abs_b;
    assign uq      = abs_a / div_b;
    assign ur      = abs_a % div_b;
    assign quo     = (a_neg ^ b_neg) ? -uq : uq;
    assign rem     = a_neg ? -ur : ur;
    assign div_res = (b_q == '0) ? {a_q, {WIDTH{1'b1}}} : {rem, quo};

    always_comb begin
        result = '0;
        case (op_q)
            OP_MULT:           result = prod_s;
            OP_MULTU:          result = prod_u;
            OP_MADD:           result = acc_q + prod_s;
            OP_MADDU:          result = acc_q + prod_u;
            OP_MSUB:           result = acc_q - prod_s;
            OP_MSUBU:          result = acc_q - prod_u;
            OP_DIV, OP_DIVU:   result = div_res;
            default:           result = '0;
        endcase
    end

    // ---------------- control ----------------
    logic is_mul, is_div;
    assign is_mul = op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
    assign is_div = op inside {OP_DIV, OP_DIVU};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        if (flush) begin
            // Flush beats both a coincident commit and a coincident start.
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (op == OP_MTHI) begin
                            hi_d = a;
                        end else if (op == OP_MTLO) begin
                            lo_d = a;
                        end else if (is_mul || is_div) begin
                            state_d = ST_RUN;
                            cnt_d   = is_div ? DIV_CNT : MUL_CNT;
                            op_d    = op;
                            a_d     = a;
                            b_d     = b;
                            acc_d   = {hi_q, lo_q};
                        end
                    end
                end
                ST_RUN: begin
                    // Counter holds the edges remaining; commit on the last one.
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        {hi_d, lo_d} = result;
                        state_d      = ST_IDLE;
                        done_d       = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q == ST_RUN);
    assign done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: default-latency instance plus a MUL_LAT=DIV_LAT=1 instance sharing stimulus.
// A transaction-level model (result computed with plain arithmetic at issue, released after LAT edges)
// is compared every cycle; directed sequences also pin hand-computed literal values.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [31:0] hi0, lo0, hi1, lo1;
    logic        busy0, done0, busy1, done1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) dut0 (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .flush(flush),
        .hi(hi0), .lo(lo0), .busy(busy0), .done(done0)
    );

    muldiv_unit #(.WIDTH(32), .MUL_LAT(1), .DIV_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .flush(flush),
        .hi(hi1), .lo(lo1), .busy(busy1), .done(done1)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        busy;
        logic        done;
        int          cnt;
        logic [63:0] res;
    } mdl_t;

    mdl_t m0, m1;

    function automatic logic [63:0] calc(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                         input logic [63:0] acc);
        int          sx, sy, q, r;
        longint      ps;
        logic [63:0] pu, res;
        sx  = int'(x);
        sy  = int'(y);
        ps  = longint'(sx) * longint'(sy);
        pu  = {32'h0, x} * {32'h0, y};
        res = 64'h0;
        case (o)
            4'd1:  res = ps;
            4'd2:  res = pu;
            4'd7:  res = acc + ps;
            4'd8:  res = acc + pu;
            4'd9:  res = acc - ps;
            4'd10: res = acc - pu;
            4'd3: begin
                if (y == 32'h0) res = {x, 32'hFFFF_FFFF};
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) res = {32'h0, x};
                else begin
                    q   = sx / sy;
                    r   = sx % sy;
                    res = {r, q};
                end
            end
            4'd4: begin
                if (y == 32'h0) res = {x, 32'hFFFF_FFFF};
                else res = {x % y, x / y};
            end
            default: res = 64'h0;
        endcase
        return res;
    endfunction

    function automatic mdl_t step(input mdl_t s, input logic rst, input logic fl, input logic st,
                                  input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                  input int ml, input int dl);
        mdl_t n;
        n      = s;
        n.done = 1'b0;
        if (rst) begin
            n.hi = 32'h0; n.lo = 32'h0; n.busy = 1'b0; n.cnt = 0;
        end else if (fl) begin
            n.busy = 1'b0; n.cnt = 0;
        end else if (s.busy) begin
            n.cnt = s.cnt - 1;
            if (n.cnt == 0) begin
                {n.hi, n.lo} = s.res;
                n.busy = 1'b0;
                n.done = 1'b1;
            end
        end else if (st) begin
            if (o == 4'd5) n.hi = x;
            else if (o == 4'd6) n.lo = x;
            else if (o inside {[4'd1:4'd4], [4'd7:4'd10]}) begin
                n.busy = 1'b1;
                n.cnt  = (o == 4'd3 || o == 4'd4) ? dl : ml;
                n.res  = calc(o, x, y, {s.hi, s.lo});
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m0 = step(m0, reset, flush, start, op, a, b, 5, 10);
        m1 = step(m1, reset, flush, start, op, a, b, 1, 1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("m0_hi", 64'(hi0), 64'(m0.hi));
            check("m0_lo", 64'(lo0), 64'(m0.lo));
            check("m0_busy", 64'(busy0), 64'(m0.busy));
            check("m0_done", 64'(done0), 64'(m0.done));
            check("m1_hi", 64'(hi1), 64'(m1.hi));
            check("m1_lo", 64'(lo1), 64'(m1.lo));
            check("m1_busy", 64'(busy1), 64'(m1.busy));
            check("m1_done", 64'(done1), 64'(m1.done));
        end
    end

    // ---------------- stimulus helpers (called #1 after a rising edge) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        tick();
        start = 1'b0; op = 4'd0; a = 32'h0; b = 32'h0;
    endtask

    // Counts cycles with busy0 high; bounded so a stuck busy shows up as a failed length check.
    task automatic run_busy(output int n);
        n = 0;
        while (busy0 && n < 300) begin
            n++;
            tick();
        end
    endtask

    int n, d;

    initial begin
        reset = 1'b1; start = 1'b0; flush = 1'b0; op = 4'd0; a = 32'h0; b = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        reset  = 1'b0;
        check("rst_hi", 64'(hi0), 64'h0);
        check("rst_lo", 64'(lo0), 64'h0);
        check("rst_busy", 64'(busy0), 64'h0);
        check("rst_done", 64'(done0), 64'h0);

        // MULT -2 * 3
        issue(4'd1, 32'hFFFF_FFFE, 32'd3);
        run_busy(n);
        check("mult_busy_len", 64'(n), 64'd5);
        check("mult_hi", 64'(hi0), 64'hFFFF_FFFF);
        check("mult_lo", 64'(lo0), 64'hFFFF_FFFA);
        check("mult_done", 64'(done0), 64'd1);
        tick();
        check("mult_done_drop", 64'(done0), 64'd0);

        // DIV -7 / 2, DIVU 7 / 0, DIV overflow
        issue(4'd3, 32'hFFFF_FFF9, 32'd2);
        run_busy(n);
        check("div_busy_len", 64'(n), 64'd10);
        check("div_lo", 64'(lo0), 64'hFFFF_FFFD);
        check("div_hi", 64'(hi0), 64'hFFFF_FFFF);
        issue(4'd4, 32'd7, 32'd0);
        run_busy(n);
        check("divu0_len", 64'(n), 64'd10);
        check("divu0_lo", 64'(lo0), 64'hFFFF_FFFF);
        check("divu0_hi", 64'(hi0), 64'd7);
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        run_busy(n);
        check("divovf_lo", 64'(lo0), 64'h8000_0000);
        check("divovf_hi", 64'(hi0), 64'h0);

        // MTLO idle, then MTLO during DIV
        issue(4'd6, 32'h1234_5678, 32'h0);
        check("mtlo_lo", 64'(lo0), 64'h1234_5678);
        check("mtlo_busy", 64'(busy0), 64'd0);
        check("mtlo_done", 64'(done0), 64'd0);
        tick();
        check("mtlo_done2", 64'(done0), 64'd0);
        issue(4'd3, 32'd100, 32'd7);
        tick(); tick();
        issue(4'd6, 32'hAAAA_5555, 32'h0);
        check("mtlo_busy_ignored", 64'(lo0), 64'h1234_5678);
        run_busy(n);
        check("div100_lo", 64'(lo0), 64'd14);
        check("div100_hi", 64'(hi0), 64'd2);

        // MADDU then MSUB, with a start ignored mid-op
        issue(4'd5, 32'h0, 32'h0);
        issue(4'd6, 32'd5, 32'h0);
        issue(4'd8, 32'd2, 32'd3);
        tick();
        issue(4'd1, 32'd9, 32'd9);
        run_busy(n);
        check("maddu_len", 64'(n), 64'd3);
        check("maddu_lo", 64'(lo0), 64'd11);
        check("maddu_hi", 64'(hi0), 64'd0);
        issue(4'd9, 32'd1, 32'd1);
        run_busy(n);
        check("msub_lo", 64'(lo0), 64'd10);
        check("msub_hi", 64'(hi0), 64'd0);

        // Flush at cycle 3 of MULTU, then flush on the commit edge
        issue(4'd5, 32'hAA, 32'h0);
        issue(4'd6, 32'hBB, 32'h0);
        issue(4'd2, 32'd5, 32'd6);
        tick(); tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", 64'(busy0), 64'd0);
        d = 0;
        for (int i = 0; i < 8; i++) begin
            if (done0) d++;
            tick();
        end
        check("flush_no_done", 64'(d), 64'd0);
        check("flush_hi", 64'(hi0), 64'hAA);
        check("flush_lo", 64'(lo0), 64'hBB);
        issue(4'd2, 32'd5, 32'd6);
        repeat (4) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flushc_busy", 64'(busy0), 64'd0);
        check("flushc_done", 64'(done0), 64'd0);
        check("flushc_lo", 64'(lo0), 64'hBB);
        check("flushc_hi", 64'(hi0), 64'hAA);

        // Reset at cycle 4 of DIV
        issue(4'd3, 32'd100, 32'd7);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstdiv_hi", 64'(hi0), 64'h0);
        check("rstdiv_lo", 64'(lo0), 64'h0);
        check("rstdiv_busy", 64'(busy0), 64'h0);
        d = 0;
        for (int i = 0; i < 15; i++) begin
            if (done0 || lo0 != 32'h0) d++;
            tick();
        end
        check("rstdiv_no_commit", 64'(d), 64'd0);

        // Latency-1 instance: busy for exactly one cycle
        issue(4'd1, 32'd3, 32'd4);
        check("lat1_mul_busy", 64'(busy1), 64'd1);
        tick();
        check("lat1_mul_busy_drop", 64'(busy1), 64'd0);
        check("lat1_mul_done", 64'(done1), 64'd1);
        check("lat1_mul_lo", 64'(lo1), 64'd12);
        run_busy(n);
        issue(4'd3, 32'd20, 32'd6);
        check("lat1_div_busy", 64'(busy1), 64'd1);
        tick();
        check("lat1_div_busy_drop", 64'(busy1), 64'd0);
        check("lat1_div_lo", 64'(lo1), 64'd3);
        check("lat1_div_hi", 64'(hi1), 64'd2);
        run_busy(n);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
